carregador_programa: RTL and testbench

Boot loader that fills the processor's 8-bit instruction memory from a byte stream before execution starts. It is the writer side of the instruction-memory interface. It receives a length byte, the program bytes and a checksum over a valid/ready stream, and writes each program byte to consecutive instruction addresses. It then pads the rest of the memory with HALT instructions and finally releases the core via `cpu_run`.

---
 rtl/carregador_programa.sv | 129 ++++++++++++
 tb/tb_carregador_programa.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/carregador_programa.sv
// Boot loader: takes length, program bytes and checksum from a valid/ready stream,
// writes them to instruction memory, pads the rest with HALT and then releases the core.
module carregador_programa #(
    parameter int unsigned MEM_DEPTH = 61,
    parameter logic [7:0]  HALT_WORD = 8'b11111000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_run,
    output logic       error,
    output logic [7:0] load_count
);

    localparam logic [7:0] DEPTH8 = 8'(MEM_DEPTH);

    typedef enum logic [2:0] {
        WAIT_LEN,
        LOAD,
        CHECK,
        FILL,
        RUN,
        ERROR
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_len;
    logic [7:0] r_sum;
    logic [7:0] r_load_count;
    logic [7:0] r_fill_addr;
    logic       r_mem_we;
    logic [7:0] r_mem_addr;
    logic [7:0] r_mem_wdata;

    logic w_xfer;
    logic w_len_bad;
    logic w_sum_ok;
    logic w_full;

    assign w_xfer    = in_valid && in_ready;
    assign w_len_bad = (in_data == 8'd0) || (in_data > DEPTH8);
    assign w_sum_ok  = (in_data == r_sum);
    assign w_full    = (r_len == DEPTH8);

    always_ff @(posedge clock) begin
        if (reset) r_state <= WAIT_LEN;
        else       r_state <= w_next_state;
    end

    // A full-length program skips FILL so cpu_run follows the checksum by one cycle.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            WAIT_LEN: if (w_xfer) w_next_state = w_len_bad ? ERROR : LOAD;
            LOAD:     if (w_xfer && (r_load_count + 8'd1 == r_len)) w_next_state = CHECK;
            CHECK:    if (w_xfer) w_next_state = !w_sum_ok ? ERROR : (w_full ? RUN : FILL);
            FILL:     if (r_fill_addr >= DEPTH8) w_next_state = RUN;
            RUN:      w_next_state = RUN;
            ERROR:    w_next_state = ERROR;
            default:  w_next_state = ERROR;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        cpu_run  = 1'b0;
        error    = 1'b0;
        unique case (r_state)
            WAIT_LEN, LOAD, CHECK: in_ready = !reset;
            RUN:                   cpu_run  = 1'b1;
            ERROR:                 error    = 1'b1;
            default:               ;
        endcase
    end

    // The first HALT write is issued on the checksum edge so FILL writes every cycle it is active.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_len        <= '0;
            r_sum        <= '0;
            r_load_count <= '0;
            r_fill_addr  <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_mem_we <= 1'b0;
            unique case (r_state)
                WAIT_LEN: if (w_xfer) begin
                    r_len        <= in_data;
                    r_sum        <= '0;
                    r_load_count <= '0;
                end
                LOAD: if (w_xfer) begin
                    r_mem_we     <= 1'b1;
                    r_mem_addr   <= r_load_count;
                    r_mem_wdata  <= in_data;
                    r_sum        <= r_sum + in_data;
                    r_load_count <= r_load_count + 8'd1;
                end
                CHECK: if (w_xfer && w_sum_ok && !w_full) begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_len;
                    r_mem_wdata <= HALT_WORD;
                    r_fill_addr <= r_len + 8'd1;
                end
                FILL: if (r_fill_addr < DEPTH8) begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_fill_addr;
                    r_mem_wdata <= HALT_WORD;
                    r_fill_addr <= r_fill_addr + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign load_count = r_load_count;

endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench for carregador_programa: table of reset/error vectors plus
// hand-written load, fill, gap and mid-fill reset sequences.
module tb_carregador_programa;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_run;
    logic       error;
    logic [7:0] load_count;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [27:0] M_ALL  = '1;
    localparam logic [27:0] M_NOAD = 28'hC0003FF;

    carregador_programa #(.MEM_DEPTH(61), .HALT_WORD(8'hF8)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_run    (cpu_run),
        .error      (error),
        .load_count (load_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  dat;
        logic [27:0] exp;
        logic [27:0] msk;
    } vec_t;

    vec_t vecs[16];

    // Packed as {in_ready, mem_we, mem_addr, mem_wdata, cpu_run, error, load_count}.
    function automatic logic [27:0] o(input logic rdy, input logic we, input logic [7:0] ad,
                                      input logic [7:0] wd, input logic run, input logic err,
                                      input logic [7:0] lc);
        return {rdy, we, ad, wd, run, err, lc};
    endfunction

    task automatic sc(input logic rst, input logic vld, input logic [7:0] dat,
                      input logic [27:0] exp, input logic [27:0] msk, input string nm);
        logic [27:0] act;
        reset    = rst;
        in_valid = vld;
        in_data  = dat;
        @(posedge clock);
        #1;
        act = {in_ready, mem_we, mem_addr, mem_wdata, cpu_run, error, load_count};
        n_vec++;
        if ((act & msk) !== (exp & msk)) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (mask %h)", nm, act, exp, msk);
        end
    endtask

    task automatic load_main();
        sc(1, 0, 8'h00, o(0,0,8'h00,8'h00,0,0,8'd0), M_ALL, "rst");
        sc(0, 1, 8'h03, o(1,0,8'h00,8'h00,0,0,8'd0), M_ALL, "len3");
        sc(0, 1, 8'h98, o(1,1,8'h00,8'h98,0,0,8'd1), M_ALL, "b0");
        sc(0, 1, 8'hE8, o(1,1,8'h01,8'hE8,0,0,8'd2), M_ALL, "b1");
        sc(0, 1, 8'h99, o(1,1,8'h02,8'h99,0,0,8'd3), M_ALL, "b2");
        sc(0, 1, 8'h19, o(0,1,8'h03,8'hF8,0,0,8'd3), M_ALL, "csum");
    endtask

    logic [7:0] prog[3];
    int unsigned gap;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        vecs[0]  = '{1, 0, 8'h00, o(0,0,8'h00,8'h00,0,0,8'd0), M_ALL};
        vecs[1]  = '{0, 0, 8'h00, o(1,0,8'h00,8'h00,0,0,8'd0), M_ALL};
        vecs[2]  = '{0, 1, 8'h03, o(1,0,8'h00,8'h00,0,0,8'd0), M_ALL};
        vecs[3]  = '{0, 1, 8'h98, o(1,1,8'h00,8'h98,0,0,8'd1), M_ALL};
        vecs[4]  = '{0, 1, 8'hE8, o(1,1,8'h01,8'hE8,0,0,8'd2), M_ALL};
        vecs[5]  = '{0, 1, 8'h99, o(1,1,8'h02,8'h99,0,0,8'd3), M_ALL};
        vecs[6]  = '{0, 1, 8'h18, o(0,0,8'h00,8'h00,0,1,8'd3), M_NOAD};
        vecs[7]  = '{0, 1, 8'h19, o(0,0,8'h00,8'h00,0,1,8'd3), M_NOAD};
        vecs[8]  = '{1, 1, 8'h00, o(0,0,8'h00,8'h00,0,0,8'd0), M_ALL};
        vecs[9]  = '{0, 1, 8'h00, o(0,0,8'h00,8'h00,0,1,8'd0), M_ALL};
        vecs[10] = '{0, 0, 8'h00, o(0,0,8'h00,8'h00,0,1,8'd0), M_ALL};
        vecs[11] = '{1, 0, 8'h00, o(0,0,8'h00,8'h00,0,0,8'd0), M_ALL};
        vecs[12] = '{0, 1, 8'h3E, o(0,0,8'h00,8'h00,0,1,8'd0), M_ALL};
        vecs[13] = '{0, 1, 8'h3D, o(0,0,8'h00,8'h00,0,1,8'd0), M_ALL};
        vecs[14] = '{1, 0, 8'h00, o(0,0,8'h00,8'h00,0,0,8'd0), M_ALL};
        vecs[15] = '{0, 1, 8'h3D, o(1,0,8'h00,8'h00,0,0,8'd0), M_ALL};

        for (int i = 0; i < 16; i++)
            sc(vecs[i].rst, vecs[i].vld, vecs[i].dat, vecs[i].exp, vecs[i].msk,
               $sformatf("vec%0d", i));

        // Maximum length: 61 bytes of 01, checksum 3D, no fill.
        for (int i = 0; i < 61; i++)
            sc(0, 1, 8'h01, o(1,1,8'(i),8'h01,0,0,8'(i+1)), M_ALL, $sformatf("max_b%0d", i));
        sc(0, 1, 8'h3D, o(0,0,8'h00,8'h00,1,0,8'd61), M_NOAD, "max_run");
        sc(0, 0, 8'h00, o(0,0,8'h00,8'h00,1,0,8'd61), M_NOAD, "max_hold");

        // Nominal full-rate stream with fill to the end of memory.
        load_main();
        for (int i = 4; i < 61; i++)
            sc(0, 0, 8'h00, o(0,1,8'(i),8'hF8,0,0,8'd3), M_ALL, $sformatf("fill%0d", i));
        sc(0, 0, 8'h00, o(0,0,8'h00,8'h00,1,0,8'd3), M_NOAD, "run");
        sc(0, 1, 8'h55, o(0,0,8'h00,8'h00,1,0,8'd3), M_NOAD, "run_ign");

        // Random in_valid gaps while loading.
        prog[0] = 8'h98;
        prog[1] = 8'hE8;
        prog[2] = 8'h99;
        sc(1, 0, 8'h00, o(0,0,8'h00,8'h00,0,0,8'd0), M_ALL, "g_rst");
        sc(0, 1, 8'h03, o(1,0,8'h00,8'h00,0,0,8'd0), M_ALL, "g_len");
        for (int b = 0; b < 3; b++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < int'(gap); g++)
                sc(0, 0, 8'hAA, o(1,0,8'h00,8'h00,0,0,8'(b)), M_NOAD, $sformatf("g_idle%0d", b));
            sc(0, 1, prog[b], o(1,1,8'(b),prog[b],0,0,8'(b+1)), M_ALL, $sformatf("g_b%0d", b));
        end
        sc(0, 0, 8'h19, o(1,0,8'h00,8'h00,0,0,8'd3), M_NOAD, "g_chk_idle");
        sc(0, 1, 8'h19, o(0,1,8'h03,8'hF8,0,0,8'd3), M_ALL, "g_csum");

        // Reset while filling at address 10, then reload a one-byte program.
        load_main();
        for (int i = 4; i <= 10; i++)
            sc(0, 0, 8'h00, o(0,1,8'(i),8'hF8,0,0,8'd3), M_ALL, $sformatf("r_fill%0d", i));
        sc(1, 0, 8'h00, o(0,0,8'h00,8'h00,0,0,8'd0), M_ALL, "r_abort");
        sc(1, 0, 8'h00, o(0,0,8'h00,8'h00,0,0,8'd0), M_ALL, "r_hold");
        sc(0, 0, 8'h00, o(1,0,8'h00,8'h00,0,0,8'd0), M_ALL, "r_idle");
        sc(0, 1, 8'h01, o(1,0,8'h00,8'h00,0,0,8'd0), M_ALL, "r_len");
        sc(0, 1, 8'hC3, o(1,1,8'h00,8'hC3,0,0,8'd1), M_ALL, "r_b0");
        sc(0, 1, 8'hC3, o(0,1,8'h01,8'hF8,0,0,8'd1), M_ALL, "r_csum");
        for (int i = 2; i < 61; i++)
            sc(0, 0, 8'h00, o(0,1,8'(i),8'hF8,0,0,8'd1), M_ALL, $sformatf("r2_fill%0d", i));
        sc(0, 0, 8'h00, o(0,0,8'h00,8'h00,1,0,8'd1), M_NOAD, "r_run");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
